// File: rtl/pong_match_ctrl.sv
// rtl/pong_match_ctrl.sv - Pong match sequencer: menu, serve countdown, play, pause, scoring and game over
//
// Ports:
//   clk_0, rst          sole clock, synchronous active-high reset
//   start_trigger       start from MENU / return to MENU from OVER
//   pause_trigger       pause toggle (SERVE/PLAY <-> PAUSE)
//   mode_choice         menu selection, latched into active_mode at start
//   point_valid,
//   point_player        point scored by the indexed player (PLAY only)
//   scores              packed per-player scores, player i at [i*SCORE_W +: SCORE_W]
//   state               MENU=0 SERVE=1 PLAY=2 PAUSE=3 OVER=4
//   game_startup, ball_enable, paused, game_over, winner, serve_player, active_mode
//                       registered status outputs
module pong_match_ctrl #(
    parameter int N_PLAYERS       = 2,
    parameter int SCORE_W         = 4,
    parameter int WIN_SCORE       = 11,
    parameter int WIN_BY          = 2,
    parameter int SERVE_DELAY_CYC = 25175000
) (
    input  logic                          clk_0,
    input  logic                          rst,
    input  logic                          start_trigger,
    input  logic                          pause_trigger,
    input  logic [1:0]                    mode_choice,
    input  logic                          point_valid,
    input  logic [1:0]                    point_player,
    output logic [N_PLAYERS*SCORE_W-1:0]  scores,
    output logic [2:0]                    state,
    output logic                          game_startup,
    output logic                          ball_enable,
    output logic                          paused,
    output logic                          game_over,
    output logic [1:0]                    winner,
    output logic [1:0]                    serve_player,
    output logic [1:0]                    active_mode
);

    localparam int CNT_W = (SERVE_DELAY_CYC > 1) ? $clog2(SERVE_DELAY_CYC) : 1;
    localparam logic [CNT_W-1:0]   CNT_LOAD  = CNT_W'(SERVE_DELAY_CYC - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    typedef enum logic [2:0] {
        ST_MENU  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    state_t                              state_q, state_d;
    state_t                              ret_q, ret_d;
    logic [CNT_W-1:0]                    cnt_q, cnt_d;
    logic [N_PLAYERS-1:0][SCORE_W-1:0]   score_q, score_d;
    logic [1:0]                          winner_d, serve_d, mode_d;

    logic                                point_ok;
    logic [SCORE_W-1:0]                  cur_score, new_score, best_other;
    logic                                scorer_wins;

    assign state  = state_q;
    assign scores = score_q;

    // Scorer's post-increment score versus the strongest opponent.
    always_comb begin
        cur_score  = '0;
        best_other = '0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            if (i == int'(point_player)) begin
                cur_score = score_q[i];
            end else if (score_q[i] > best_other) begin
                best_other = score_q[i];
            end
        end
        new_score   = (cur_score == SCORE_MAX) ? SCORE_MAX : cur_score + 1'b1;
        point_ok    = point_valid && (int'(point_player) < N_PLAYERS);
        // A saturated score cannot grow any further, so it ends the match outright.
        scorer_wins = (new_score == SCORE_MAX) ||
                      ((int'(new_score) >= WIN_SCORE) &&
                       (int'(new_score) - int'(best_other) >= WIN_BY));
    end

    always_comb begin
        state_d  = state_q;
        ret_d    = ret_q;
        cnt_d    = cnt_q;
        score_d  = score_q;
        winner_d = winner;
        serve_d  = serve_player;
        mode_d   = active_mode;
        case (state_q)
            ST_MENU: begin
                if (start_trigger) begin
                    mode_d  = mode_choice;
                    score_d = '0;
                    serve_d = '0;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_SERVE;
                end
            end
            ST_SERVE: begin
                // Pause wins over countdown expiry so the count stays frozen.
                if (pause_trigger) begin
                    ret_d   = ST_SERVE;
                    state_d = ST_PAUSE;
                end else if (cnt_q == '0) begin
                    state_d = ST_PLAY;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_PLAY: begin
                // A point in the same cycle as a pause takes precedence.
                if (point_ok) begin
                    for (int i = 0; i < N_PLAYERS; i++) begin
                        if (i == int'(point_player)) begin
                            score_d[i] = new_score;
                        end
                    end
                    serve_d = point_player;
                    if (scorer_wins) begin
                        winner_d = point_player;
                        state_d  = ST_OVER;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = ST_SERVE;
                    end
                end else if (pause_trigger) begin
                    ret_d   = ST_PLAY;
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (pause_trigger) begin
                    state_d = ret_q;
                end
            end
            ST_OVER: begin
                if (start_trigger) begin
                    state_d = ST_MENU;
                end
            end
            default: state_d = ST_MENU;
        endcase
    end

    always_ff @(posedge clk_0) begin
        if (rst) begin
            state_q      <= ST_MENU;
            ret_q        <= ST_MENU;
            cnt_q        <= '0;
            score_q      <= '0;
            winner       <= '0;
            serve_player <= '0;
            active_mode  <= '0;
            game_startup <= 1'b1;
            ball_enable  <= 1'b0;
            paused       <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            cnt_q        <= cnt_d;
            score_q      <= score_d;
            winner       <= winner_d;
            serve_player <= serve_d;
            active_mode  <= mode_d;
            game_startup <= (state_d == ST_MENU);
            ball_enable  <= (state_d == ST_PLAY);
            paused       <= (state_d == ST_PAUSE);
            game_over    <= (state_d == ST_OVER);
        end
    end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb/tb_pong_match_ctrl.sv - self-checking bench for pong_match_ctrl
module tb_pong_match_ctrl;

    localparam int D  = 4;
    localparam int WS = 3;
    localparam int WB = 2;

    logic clk_0 = 1'b0;
    always #5 clk_0 = ~clk_0;

    logic       rst = 1'b1;
    logic       start_trigger = 1'b0;
    logic       pause_trigger = 1'b0;
    logic [1:0] mode_choice = 2'd0;
    logic       point_valid = 1'b0;
    logic [1:0] point_player = 2'd0;

    logic [7:0] scores_a;
    logic [2:0] state_a;
    logic       gs_a, be_a, pa_a, go_a;
    logic [1:0] win_a, srv_a, mode_a;

    logic [3:0] scores_b;
    logic [2:0] state_b;
    logic       gs_b, be_b, pa_b, go_b;
    logic [1:0] win_b, srv_b, mode_b;

    pong_match_ctrl #(
        .N_PLAYERS(2), .SCORE_W(4), .WIN_SCORE(WS), .WIN_BY(WB), .SERVE_DELAY_CYC(D)
    ) dut (
        .clk_0(clk_0), .rst(rst), .start_trigger(start_trigger), .pause_trigger(pause_trigger),
        .mode_choice(mode_choice), .point_valid(point_valid), .point_player(point_player),
        .scores(scores_a), .state(state_a), .game_startup(gs_a), .ball_enable(be_a),
        .paused(pa_a), .game_over(go_a), .winner(win_a), .serve_player(srv_a),
        .active_mode(mode_a)
    );

    pong_match_ctrl #(
        .N_PLAYERS(2), .SCORE_W(2), .WIN_SCORE(WS), .WIN_BY(WB), .SERVE_DELAY_CYC(D)
    ) dut2 (
        .clk_0(clk_0), .rst(rst), .start_trigger(start_trigger), .pause_trigger(pause_trigger),
        .mode_choice(mode_choice), .point_valid(point_valid), .point_player(point_player),
        .scores(scores_b), .state(state_b), .game_startup(gs_b), .ball_enable(be_b),
        .paused(pa_b), .game_over(go_b), .winner(win_b), .serve_player(srv_b),
        .active_mode(mode_b)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: one instance per DUT (0: 4-bit scores, 1: 2-bit scores).
    int m_st[2], m_cnt[2], m_ret[2], m_win[2], m_srv[2], m_mode[2];
    int m_sc[2][2];
    int m_max[2] = '{15, 3};

    task automatic model_step(input int k);
        int p, o, ns;
        if (rst) begin
            m_st[k] = 0; m_cnt[k] = 0; m_ret[k] = 0; m_win[k] = 0;
            m_srv[k] = 0; m_mode[k] = 0; m_sc[k][0] = 0; m_sc[k][1] = 0;
            return;
        end
        case (m_st[k])
            0: if (start_trigger) begin
                m_mode[k] = int'(mode_choice);
                m_sc[k][0] = 0; m_sc[k][1] = 0; m_srv[k] = 0;
                m_st[k] = 1; m_cnt[k] = D - 1;
            end
            1: if (pause_trigger) begin
                m_ret[k] = 1; m_st[k] = 3;
            end else if (m_cnt[k] == 0) begin
                m_st[k] = 2;
            end else begin
                m_cnt[k] = m_cnt[k] - 1;
            end
            2: if (point_valid && int'(point_player) < 2) begin
                p = int'(point_player);
                o = 1 - p;
                ns = (m_sc[k][p] + 1 > m_max[k]) ? m_max[k] : m_sc[k][p] + 1;
                m_sc[k][p] = ns;
                m_srv[k] = p;
                if (ns == m_max[k] || (ns >= WS && ns - m_sc[k][o] >= WB)) begin
                    m_st[k] = 4; m_win[k] = p;
                end else begin
                    m_st[k] = 1; m_cnt[k] = D - 1;
                end
            end else if (pause_trigger) begin
                m_ret[k] = 2; m_st[k] = 3;
            end
            3: if (pause_trigger) m_st[k] = m_ret[k];
            4: if (start_trigger) m_st[k] = 0;
            default: ;
        endcase
    endtask

    task automatic check_model(input int k);
        logic [31:0] sc, st, gs, be, pa, go, wn, sv, md;
        int exp_sc;
        if (k == 0) begin
            sc = 32'(scores_a); st = 32'(state_a); gs = 32'(gs_a); be = 32'(be_a); pa = 32'(pa_a);
            go = 32'(go_a); wn = 32'(win_a); sv = 32'(srv_a); md = 32'(mode_a);
            exp_sc = m_sc[0][0] + m_sc[0][1] * 16;
        end else begin
            sc = 32'(scores_b); st = 32'(state_b); gs = 32'(gs_b); be = 32'(be_b); pa = 32'(pa_b);
            go = 32'(go_b); wn = 32'(win_b); sv = 32'(srv_b); md = 32'(mode_b);
            exp_sc = m_sc[1][0] + m_sc[1][1] * 4;
        end
        check($sformatf("rnd%0d_state", k), st, m_st[k]);
        check($sformatf("rnd%0d_scores", k), sc, exp_sc);
        check($sformatf("rnd%0d_startup", k), gs, (m_st[k] == 0) ? 1 : 0);
        check($sformatf("rnd%0d_ball", k), be, (m_st[k] == 2) ? 1 : 0);
        check($sformatf("rnd%0d_paused", k), pa, (m_st[k] == 3) ? 1 : 0);
        check($sformatf("rnd%0d_over", k), go, (m_st[k] == 4) ? 1 : 0);
        check($sformatf("rnd%0d_winner", k), wn, m_win[k]);
        check($sformatf("rnd%0d_serve", k), sv, m_srv[k]);
        check($sformatf("rnd%0d_mode", k), md, m_mode[k]);
    endtask

    task automatic step(input logic r, input logic s, input logic p, input logic [1:0] mc,
                        input logic v, input logic [1:0] pp);
        @(negedge clk_0);
        rst = r; start_trigger = s; pause_trigger = p;
        mode_choice = mc; point_valid = v; point_player = pp;
        @(posedge clk_0);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
    endtask

    task automatic point(input logic [1:0] pp);
        step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, pp);
    endtask

    task automatic wait_play();
        int n;
        n = 0;
        while (state_a !== 3'd2 && n < 20) begin
            idle();
            n++;
        end
        check("reach_play", 32'(state_a), 2);
    endtask

    typedef struct {
        logic       r, s, p;
        logic [1:0] mc;
        logic       v;
        logic [1:0] pp;
        logic [2:0] st;
        logic       chk_sc;
        logic [7:0] sc;
        logic       be, go;
        logic [1:0] win, mode;
    } vec_t;

    vec_t tbl[21];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          r s p mc v pp  st chk sc     be go win mode
        tbl[0]  = '{1,0,0,0, 0,0,  0, 1, 8'h00, 0, 0, 0, 0};
        tbl[1]  = '{0,1,0,2, 0,0,  1, 1, 8'h00, 0, 0, 0, 2};
        tbl[2]  = '{0,0,0,0, 0,0,  1, 1, 8'h00, 0, 0, 0, 2};
        tbl[3]  = '{0,0,0,0, 0,0,  1, 1, 8'h00, 0, 0, 0, 2};
        tbl[4]  = '{0,0,0,0, 0,0,  1, 1, 8'h00, 0, 0, 0, 2};
        tbl[5]  = '{0,0,0,0, 0,0,  2, 1, 8'h00, 1, 0, 0, 2};
        tbl[6]  = '{0,0,0,0, 1,3,  2, 1, 8'h00, 1, 0, 0, 2};
        tbl[7]  = '{0,0,0,0, 1,0,  1, 1, 8'h01, 0, 0, 0, 2};
        tbl[8]  = '{0,0,0,0, 1,1,  1, 1, 8'h01, 0, 0, 0, 2};
        tbl[9]  = '{0,0,0,0, 0,0,  1, 1, 8'h01, 0, 0, 0, 2};
        tbl[10] = '{0,0,0,0, 0,0,  1, 1, 8'h01, 0, 0, 0, 2};
        tbl[11] = '{0,0,0,0, 0,0,  2, 1, 8'h01, 1, 0, 0, 2};
        tbl[12] = '{0,0,1,0, 1,0,  1, 1, 8'h02, 0, 0, 0, 2};
        tbl[13] = '{0,0,0,0, 0,0,  1, 1, 8'h02, 0, 0, 0, 2};
        tbl[14] = '{0,0,0,0, 0,0,  1, 1, 8'h02, 0, 0, 0, 2};
        tbl[15] = '{0,0,0,0, 0,0,  1, 1, 8'h02, 0, 0, 0, 2};
        tbl[16] = '{0,0,0,0, 0,0,  2, 1, 8'h02, 1, 0, 0, 2};
        tbl[17] = '{0,0,0,0, 1,0,  4, 1, 8'h03, 0, 1, 0, 2};
        tbl[18] = '{0,0,1,0, 0,0,  4, 1, 8'h03, 0, 1, 0, 2};
        tbl[19] = '{0,1,0,1, 0,0,  0, 0, 8'h03, 0, 0, 0, 2};
        tbl[20] = '{0,1,0,1, 0,0,  1, 1, 8'h00, 0, 0, 0, 1};

        for (int i = 0; i < 21; i++) begin
            step(tbl[i].r, tbl[i].s, tbl[i].p, tbl[i].mc, tbl[i].v, tbl[i].pp);
            check($sformatf("tbl%0d_state", i), 32'(state_a), 32'(tbl[i].st));
            if (tbl[i].chk_sc) check($sformatf("tbl%0d_scores", i), 32'(scores_a), 32'(tbl[i].sc));
            check($sformatf("tbl%0d_ball", i), 32'(be_a), 32'(tbl[i].be));
            check($sformatf("tbl%0d_over", i), 32'(go_a), 32'(tbl[i].go));
            check($sformatf("tbl%0d_winner", i), 32'(win_a), 32'(tbl[i].win));
            check($sformatf("tbl%0d_mode", i), 32'(mode_a), 32'(tbl[i].mode));
            if (i == 0) check("tbl0_startup", 32'(gs_a), 1);
        end

        // 2-2, then player 1 scores twice: 2-3 keeps playing, 2-4 wins.
        step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        step(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0);
        wait_play(); point(2'd0);
        wait_play(); point(2'd1);
        wait_play(); point(2'd0);
        wait_play(); point(2'd1);
        wait_play();
        check("deuce_scores", 32'(scores_a), 32'h22);
        check("deuce_scores_sat", 32'(scores_b), 32'hA);
        point(2'd1);
        check("adv_scores", 32'(scores_a), 32'h32);
        check("adv_state", 32'(state_a), 1);
        check("adv_serve", 32'(srv_a), 1);
        wait_play(); point(2'd1);
        check("win1_scores", 32'(scores_a), 32'h42);
        check("win1_state", 32'(state_a), 4);
        check("win1_winner", 32'(win_a), 1);
        check("win1_over", 32'(go_a), 1);

        // Pause in SERVE with countdown at 2, hold 10 cycles, resume for 3 SERVE cycles.
        step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        step(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0);
        idle();
        step(1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0);
        check("pause_state", 32'(state_a), 3);
        check("pause_flag", 32'(pa_a), 1);
        for (int i = 0; i < 10; i++) begin
            idle();
            check($sformatf("pause_hold%0d", i), 32'(state_a), 3);
        end
        step(1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0);
        check("resume_serve0", 32'(state_a), 1);
        idle();
        check("resume_serve1", 32'(state_a), 1);
        idle();
        check("resume_serve2", 32'(state_a), 1);
        idle();
        check("resume_play", 32'(state_a), 2);
        check("resume_ball", 32'(be_a), 1);

        // Saturating 2-bit scores: 2-2 then player 0 reaches 3, which wins despite a lead of 1.
        step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        step(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0);
        wait_play(); point(2'd0);
        wait_play(); point(2'd1);
        wait_play(); point(2'd0);
        wait_play(); point(2'd1);
        wait_play(); point(2'd0);
        check("sat_scores", 32'(scores_b), 32'hB);
        check("sat_state", 32'(state_b), 4);
        check("sat_winner", 32'(win_b), 0);
        check("sat_over", 32'(go_b), 1);
        check("nosat_state", 32'(state_a), 1);

        // Reset in the middle of PLAY at 2-1.
        step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        step(1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 2'd0);
        wait_play(); point(2'd0);
        wait_play(); point(2'd0);
        wait_play(); point(2'd1);
        wait_play();
        check("mid_scores", 32'(scores_a), 32'h12);
        step(1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0);
        check("rst_state", 32'(state_a), 0);
        check("rst_scores", 32'(scores_a), 0);
        check("rst_mode", 32'(mode_a), 0);
        check("rst_startup", 32'(gs_a), 1);
        check("rst_scores_sat", 32'(scores_b), 0);

        // Randomized traffic against the reference model for both DUTs.
        step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(99) == 0),
                 ($urandom_range(9) == 0),
                 ($urandom_range(19) == 0),
                 2'($urandom_range(3)),
                 ($urandom_range(2) == 0),
                 2'($urandom_range(3)));
            check_model(0);
            check_model(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
